// File: rtl/goertzel_pkg.sv
// Shared types and constants for the Goertzel sequencer and its register file.
package goertzel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CORDIC,
        WAIT_COEF,
        ACQ,
        FLUSH,
        DONE
    } seq_state_t;

    // Bit positions inside the 3-bit err status field
    localparam int ERR_CFG = 0;
    localparam int ERR_OVR = 1;
    localparam int ERR_TMO = 2;

    localparam logic [7:0] STATUS_CORDIC_MSK = 8'h01;
    localparam logic [7:0] STATUS_HERZEL_MSK = 8'h02;

endpackage

// File: rtl/adc_strobe_sync.sv
// Brings an asynchronous ADC strobe into the clk domain and captures the sample
// on the detected rising edge; stb is a one-cycle registered pulse.
module adc_strobe_sync #(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          adc_en,
    input  logic [SW-1:0] adc_data,
    output logic          stb,
    output logic [SW-1:0] data
);

    // [0],[1] metastability chain, [2] previous synchronized level
    logic [2:0] en_pipe;
    logic       rise;

    assign rise = en_pipe[1] & ~en_pipe[2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_pipe <= '0;
            stb     <= 1'b0;
            data    <= '0;
        end else if (clr) begin
            en_pipe <= '0;
            stb     <= 1'b0;
            data    <= '0;
        end else begin
            en_pipe <= {en_pipe[1:0], adc_en};
            stb     <= rise;
            if (rise)
                data <= adc_data;
        end
    end

endmodule

// File: rtl/goertzel_seq_ctrl.sv
// Run sequencer for the Goertzel bank: clear, coefficient generation, sample
// capture of a latched length, then wait for every bin to report valid.
module goertzel_seq_ctrl
    import goertzel_pkg::*;
#(
    parameter int NF  = 12,
    parameter int SW  = 8,
    parameter int CW  = 32,
    parameter int TMO = 65535
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          soft_rst,
    input  logic          start,
    input  logic [CW-1:0] num_samp,
    output logic          cordic_start,
    input  logic          cordic_done,
    output logic          herz_clr,
    input  logic          adc_en,
    input  logic [SW-1:0] adc_data,
    input  logic          samp_ready,
    output logic          samp_valid,
    output logic [SW-1:0] samp_data,
    output logic          samp_last,
    input  logic [NF-1:0] herz_valid,
    output logic          busy,
    output logic          cordic_ok,
    output logic          herz_done,
    output logic [2:0]    err
);

    localparam int TW = $clog2(TMO + 1);

    seq_state_t    state, state_d;
    logic [CW-1:0] ns_q;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          stb;
    logic [SW-1:0] sd;

    logic arm, set_cfg, set_tmo, set_ovr, set_hd, ack_coef, emit, last;

    adc_strobe_sync #(.SW(SW)) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (soft_rst),
        .adc_en   (adc_en),
        .adc_data (adc_data),
        .stb      (stb),
        .data     (sd)
    );

    assign tmo_hit = (tmo_cnt == TW'(TMO));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         state <= IDLE;
        else if (soft_rst) state <= IDLE;
        else               state <= state_d;
    end

    always_comb begin
        state_d  = state;
        arm      = 1'b0;
        set_cfg  = 1'b0;
        set_tmo  = 1'b0;
        set_ovr  = 1'b0;
        set_hd   = 1'b0;
        ack_coef = 1'b0;
        emit     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    arm = 1'b1;
                    if (num_samp == '0) begin
                        set_cfg = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = CORDIC;
                    end
                end
            end
            CORDIC: state_d = WAIT_COEF;
            WAIT_COEF: begin
                if (cordic_done) begin
                    ack_coef = 1'b1;
                    state_d  = ACQ;
                end else if (tmo_hit) begin
                    set_tmo = 1'b1;
                    state_d = DONE;
                end
            end
            ACQ: begin
                if (stb) begin
                    if (samp_ready) begin
                        emit = 1'b1;
                        if ((cnt + CW'(1)) == ns_q) begin
                            last    = 1'b1;
                            state_d = FLUSH;
                        end
                    end else begin
                        set_ovr = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (&herz_valid) begin
                    set_hd  = 1'b1;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    set_tmo = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear and coefficient kick share the single CORDIC-state cycle
    assign cordic_start = (state == CORDIC);
    assign herz_clr     = (state == CORDIC);
    assign busy         = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ns_q       <= '0;
            cnt        <= '0;
            tmo_cnt    <= '0;
            samp_valid <= 1'b0;
            samp_data  <= '0;
            samp_last  <= 1'b0;
            cordic_ok  <= 1'b0;
            herz_done  <= 1'b0;
            err        <= '0;
        end else if (soft_rst) begin
            ns_q       <= '0;
            cnt        <= '0;
            tmo_cnt    <= '0;
            samp_valid <= 1'b0;
            samp_data  <= '0;
            samp_last  <= 1'b0;
            cordic_ok  <= 1'b0;
            herz_done  <= 1'b0;
            err        <= '0;
        end else begin
            if (state_d != state) tmo_cnt <= '0;
            else if (!tmo_hit)    tmo_cnt <= tmo_cnt + TW'(1);

            samp_valid <= emit;
            samp_last  <= last;
            // Offset-binary to two's complement
            if (emit) begin
                samp_data <= {~sd[SW-1], sd[SW-2:0]};
                cnt       <= cnt + CW'(1);
            end

            if (arm) begin
                ns_q      <= num_samp;
                err       <= '0;
                cordic_ok <= 1'b0;
                herz_done <= 1'b0;
            end
            if (set_cfg) err[ERR_CFG] <= 1'b1;
            if (set_ovr) err[ERR_OVR] <= 1'b1;
            if (set_tmo) err[ERR_TMO] <= 1'b1;
            if (set_hd)  herz_done    <= 1'b1;
            if (ack_coef) begin
                cordic_ok <= 1'b1;
                cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_goertzel_seq_ctrl.sv
// Directed bench for goertzel_seq_ctrl: run flow, data mapping, latency,
// overrun, timeouts, config error and soft abort.
module tb_goertzel_seq_ctrl;

    localparam int NF    = 12;
    localparam int SW    = 8;
    localparam int CW    = 32;
    localparam int TMO_T = 300;

    logic          clk = 1'b0;
    logic          rstn, soft_rst, start, cordic_done, adc_en, samp_ready;
    logic [CW-1:0] num_samp;
    logic [SW-1:0] adc_data;
    logic [NF-1:0] herz_valid;
    logic          cordic_start, herz_clr, samp_valid, samp_last, busy, cordic_ok, herz_done;
    logic [SW-1:0] samp_data;
    logic [2:0]    err;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_last = 0, n_cstart = 0, last_at = 0;

    logic [7:0] din  [3] = '{8'h00, 8'h80, 8'hFF};
    logic [7:0] dexp [3] = '{8'h80, 8'h00, 8'h7F};

    goertzel_seq_ctrl #(.NF(NF), .SW(SW), .CW(CW), .TMO(TMO_T)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .soft_rst     (soft_rst),
        .start        (start),
        .num_samp     (num_samp),
        .cordic_start (cordic_start),
        .cordic_done  (cordic_done),
        .herz_clr     (herz_clr),
        .adc_en       (adc_en),
        .adc_data     (adc_data),
        .samp_ready   (samp_ready),
        .samp_valid   (samp_valid),
        .samp_data    (samp_data),
        .samp_last    (samp_last),
        .herz_valid   (herz_valid),
        .busy         (busy),
        .cordic_ok    (cordic_ok),
        .herz_done    (herz_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (samp_valid) n_valid++;
        if (samp_last) begin
            n_last++;
            last_at = n_valid;
        end
        if (cordic_start) n_cstart++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CW-1:0] n);
        num_samp = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic send_edge(input logic [7:0] d);
        adc_data = d;
        adc_en   = 1'b1;
        repeat (4) tick();
        adc_en   = 1'b0;
        repeat (16) tick();
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({busy, cordic_start, herz_clr, samp_valid, samp_last, cordic_ok, herz_done} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000000",
                {busy, cordic_start, herz_clr, samp_valid, samp_last, cordic_ok, herz_done});
        end
        checks++;
        if (err !== 3'b000 || samp_data !== 8'h00) begin
            errors++; $display("FAIL reset_err_data: err %b data %h want 000/00", err, samp_data);
        end
        rstn = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || err !== 3'b000) begin
            errors++; $display("FAIL reset_release: busy %b err %b want 0/000", busy, err);
        end
    endtask

    task automatic test_happy();
        int bv, bl;
        bv = n_valid; bl = n_last;
        start_run(200);
        checks++;
        if (cordic_start !== 1'b1 || herz_clr !== 1'b1) begin
            errors++; $display("FAIL happy_kick: cordic_start %b herz_clr %b want 1/1", cordic_start, herz_clr);
        end
        num_samp = 7;              // must not affect the latched length
        send_edge(8'h55);          // arrives in WAIT_COEF, discarded
        repeat (80) tick();
        cordic_done = 1'b1;
        repeat (2) tick();
        checks++;
        if (cordic_ok !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL happy_cordic_ok: cordic_ok %b busy %b want 1/1", cordic_ok, busy);
        end
        for (int i = 0; i < 200; i++) send_edge(8'(i));
        checks++;
        if (n_valid - bv !== 200 || last_at - bv !== 200 || n_last - bl !== 1) begin
            errors++; $display("FAIL happy_count: valid %0d last_at %0d lasts %0d want 200/200/1",
                n_valid - bv, last_at - bv, n_last - bl);
        end
        checks++;
        if (samp_data !== 8'h47 || herz_done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL happy_flush: data %h herz_done %b busy %b want 47/0/1",
                samp_data, herz_done, busy);
        end
        repeat (4) tick();
        herz_valid = '1;
        repeat (2) tick();
        checks++;
        if (herz_done !== 1'b1 || err !== 3'b000 || busy !== 1'b0) begin
            errors++; $display("FAIL happy_done: herz_done %b err %b busy %b want 1/000/0", herz_done, err, busy);
        end
        herz_valid  = '0;
        cordic_done = 1'b0;
    endtask

    task automatic test_data_latency();
        start_run(3);
        cordic_done = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            adc_data = din[i];
            adc_en   = 1'b1;
            repeat (3) tick();
            checks++;
            if (samp_valid !== 1'b0) begin
                errors++; $display("FAIL latency_early[%0d]: samp_valid %b want 0", i, samp_valid);
            end
            tick();
            checks++;
            if (samp_valid !== 1'b1 || samp_data !== dexp[i] || samp_last !== (i == 2)) begin
                errors++; $display("FAIL data_map[%0d]: valid %b data %h last %b want 1/%h/%0d",
                    i, samp_valid, samp_data, samp_last, dexp[i], (i == 2));
            end
            adc_en = 1'b0;
            repeat (10) tick();
        end
        herz_valid = '1;
        repeat (2) tick();
        checks++;
        if (herz_done !== 1'b1 || err !== 3'b000) begin
            errors++; $display("FAIL data_done: herz_done %b err %b want 1/000", herz_done, err);
        end
        herz_valid  = '0;
        cordic_done = 1'b0;
    endtask

    task automatic test_overrun();
        int bv, bl;
        bv = n_valid; bl = n_last;
        start_run(20);
        cordic_done = 1'b1;
        repeat (2) tick();
        for (int e = 1; e <= 20; e++) begin
            samp_ready = (e != 10);
            send_edge(8'(e));
            samp_ready = 1'b1;
        end
        checks++;
        if (n_last - bl !== 0 || n_valid - bv !== 19) begin
            errors++; $display("FAIL ovr_20: lasts %0d valid %0d want 0/19", n_last - bl, n_valid - bv);
        end
        send_edge(8'd21);
        checks++;
        if (n_last - bl !== 1 || n_valid - bv !== 20 || last_at - bv !== 20 || err !== 3'b010) begin
            errors++; $display("FAIL ovr_21: lasts %0d valid %0d last_at %0d err %b want 1/20/20/010",
                n_last - bl, n_valid - bv, last_at - bv, err);
        end
        herz_valid = '1;
        repeat (2) tick();
        checks++;
        if (herz_done !== 1'b1 || err !== 3'b010) begin
            errors++; $display("FAIL ovr_done: herz_done %b err %b want 1/010", herz_done, err);
        end
        herz_valid  = '0;
        cordic_done = 1'b0;
    endtask

    task automatic test_cordic_timeout();
        int bc, k;
        bc = n_cstart;
        start_run(10);
        k = 0;
        while (err === 3'b000 && k < TMO_T + 20) begin
            tick();
            k++;
        end
        checks++;
        if (k !== TMO_T + 2) begin
            errors++; $display("FAIL coef_tmo_cycles: got %0d want %0d", k, TMO_T + 2);
        end
        repeat (5) tick();
        checks++;
        if (err !== 3'b100 || herz_done !== 1'b0 || busy !== 1'b0 || n_cstart - bc !== 1) begin
            errors++; $display("FAIL coef_tmo: err %b herz_done %b busy %b kicks %0d want 100/0/0/1",
                err, herz_done, busy, n_cstart - bc);
        end
    endtask

    task automatic test_flush_timeout();
        start_run(2);
        cordic_done = 1'b1;
        repeat (2) tick();
        send_edge(8'h01);
        send_edge(8'h02);
        herz_valid = 12'hFFE;
        checks++;
        if (busy !== 1'b1 || err !== 3'b000) begin
            errors++; $display("FAIL flush_wait: busy %b err %b want 1/000", busy, err);
        end
        repeat (TMO_T + 10) tick();
        checks++;
        if (err !== 3'b100 || herz_done !== 1'b0 || cordic_ok !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_tmo: err %b herz_done %b cordic_ok %b busy %b want 100/0/1/0",
                err, herz_done, cordic_ok, busy);
        end
        herz_valid  = '0;
        cordic_done = 1'b0;
    endtask

    task automatic test_cfg();
        int bc;
        bc = n_cstart;
        start_run(0);
        checks++;
        if (err !== 3'b001 || busy !== 1'b0 || herz_done !== 1'b0 || cordic_ok !== 1'b0) begin
            errors++; $display("FAIL cfg: err %b busy %b herz_done %b cordic_ok %b want 001/0/0/0",
                err, busy, herz_done, cordic_ok);
        end
        repeat (5) tick();
        checks++;
        if (n_cstart - bc !== 0 || herz_clr !== 1'b0) begin
            errors++; $display("FAIL cfg_nokick: kicks %0d herz_clr %b want 0/0", n_cstart - bc, herz_clr);
        end
    endtask

    task automatic test_abort_rerun();
        int bv, bl;
        start_run(16);
        cordic_done = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) send_edge(8'(i));
        bl = n_last;
        soft_rst = 1'b1;
        start    = 1'b1;       // soft_rst must win
        tick();
        start    = 1'b0;
        tick();
        checks++;
        if ({busy, cordic_start, herz_clr, samp_valid, samp_last, cordic_ok, herz_done} !== 7'b0 ||
            err !== 3'b000) begin
            errors++; $display("FAIL abort: ctrl %b err %b want 0000000/000",
                {busy, cordic_start, herz_clr, samp_valid, samp_last, cordic_ok, herz_done}, err);
        end
        soft_rst    = 1'b0;
        cordic_done = 1'b0;
        repeat (3) tick();
        checks++;
        if (n_last - bl !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_nolast: lasts %0d busy %b want 0/0", n_last - bl, busy);
        end
        bv = n_valid; bl = n_last;
        start_run(16);
        cordic_done = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 16; i++) send_edge(8'h10 + 8'(i));
        herz_valid = '1;
        repeat (2) tick();
        checks++;
        if (n_valid - bv !== 16 || last_at - bv !== 16 || n_last - bl !== 1 ||
            herz_done !== 1'b1 || err !== 3'b000) begin
            errors++; $display("FAIL rerun: valid %0d last_at %0d lasts %0d herz_done %b err %b want 16/16/1/1/000",
                n_valid - bv, last_at - bv, n_last - bl, herz_done, err);
        end
        herz_valid  = '0;
        cordic_done = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        soft_rst    = 1'b0;
        start       = 1'b0;
        num_samp    = '0;
        cordic_done = 1'b0;
        adc_en      = 1'b0;
        adc_data    = '0;
        samp_ready  = 1'b1;
        herz_valid  = '0;
        test_reset();
        test_happy();
        test_data_latency();
        test_overrun();
        test_cordic_timeout();
        test_flush_timeout();
        test_cfg();
        test_abort_rerun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
